// File: rtl/lexington_pkg.sv
// rtl/lexington_pkg.sv - shared types, register offsets and helpers for the gptim timer
package lexington_pkg;

  localparam int GPTIM_ADDR_WIDTH = 4;
  localparam int GPTIM_PSC_WIDTH  = 16;

  localparam logic [1:0] GPTIM_CONF = 2'd0;
  localparam logic [1:0] GPTIM_CNT  = 2'd1;
  localparam logic [1:0] GPTIM_CMP  = 2'd2;
  localparam logic [1:0] GPTIM_DUTY = 2'd3;

  typedef struct packed {
    logic [GPTIM_PSC_WIDTH-1:0] psc;
    logic [11:0]                rsvd;
    logic                       pend;
    logic                       ie;
    logic                       oneshot;
    logic                       en;
  } gptim_conf_t;

  function automatic logic [31:0] gptim_byte_merge(input logic [31:0] old_v,
                                                   input logic [31:0] new_v,
                                                   input logic [3:0]  we);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gptim_prescaler.sv
// rtl/gptim_prescaler.sv - clock prescaler producing one tick every PSC+1 enabled cycles
module gptim_prescaler
  import lexington_pkg::*;
#(
  parameter int PSC_WIDTH = GPTIM_PSC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [PSC_WIDTH-1:0] i_psc,
  input  logic                 i_clear,
  output logic                 o_tick
);

  logic [PSC_WIDTH-1:0] r_psc_cnt;

  assign o_tick = i_en & (r_psc_cnt == i_psc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc_cnt <= '0;
    end else if (!i_en || i_clear || o_tick) begin
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gptim.sv
// rtl/gptim.sv - general-purpose up-counting timer with prescaler, compare-reload and level irq
// Optional PWM output and DUTY register are built only when GPTIM_PWM_EN is defined.
module gptim
  import lexington_pkg::*;
#(
  parameter int ADDR_WIDTH = GPTIM_ADDR_WIDTH,
  parameter int PSC_WIDTH  = GPTIM_PSC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_en,
  input  logic [3:0]            bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wr_data,
  output logic [31:0]           bus_rd_data,
  output logic                  irq,
  output logic                  pwm_out
);

  gptim_conf_t r_conf;
  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic [31:0] r_rd_data;

  logic [1:0]  w_word;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_conf;
  logic        w_wr_cnt;
  logic        w_wr_cmp;
  logic        w_conf_lo;
  logic        w_psc_wr;
  logic        w_w1c;
  logic        w_tick;
  logic        w_match;
  logic        w_clear;
  logic [15:0] w_psc_next;
  logic [31:0] w_duty_rd;
  logic [31:0] w_rd_mux;
  logic        w_unused_addr;

  assign w_word        = bus_addr[3:2];
  assign w_unused_addr = ^bus_addr[1:0];
  assign w_wr          = bus_en & (|bus_we);
  assign w_rd          = bus_en & ~(|bus_we);
  assign w_wr_conf     = w_wr & (w_word == GPTIM_CONF);
  assign w_wr_cnt      = w_wr & (w_word == GPTIM_CNT);
  assign w_wr_cmp      = w_wr & (w_word == GPTIM_CMP);
  assign w_conf_lo     = w_wr_conf & bus_we[0];
  assign w_psc_wr      = w_wr_conf & (bus_we[2] | bus_we[3]);
  assign w_w1c         = w_conf_lo & bus_wr_data[3];
  assign w_psc_next    = {bus_we[3] ? bus_wr_data[31:24] : r_conf.psc[15:8],
                          bus_we[2] ? bus_wr_data[23:16] : r_conf.psc[7:0]};

  // Restarting the prescale phase on CNT or PSC writes keeps the first period full length.
  assign w_clear = w_wr_cnt | w_psc_wr;

  gptim_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_conf.en),
    .i_psc   (r_conf.psc[PSC_WIDTH-1:0]),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  assign w_match = w_tick & (r_cnt == r_cmp);

  // Software writes are applied after hardware events so they win; a new match beats W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conf <= '0;
    end else begin
      if (w_match) begin
        r_conf.pend <= 1'b1;
        if (r_conf.oneshot) r_conf.en <= 1'b0;
      end else if (w_w1c) begin
        r_conf.pend <= 1'b0;
      end
      if (w_conf_lo) begin
        r_conf.en      <= bus_wr_data[0];
        r_conf.oneshot <= bus_wr_data[1];
        r_conf.ie      <= bus_wr_data[2];
      end
      if (w_psc_wr) r_conf.psc <= w_psc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_cmp <= '0;
    end else begin
      if (w_wr_cnt)     r_cnt <= gptim_byte_merge(r_cnt, bus_wr_data, bus_we);
      else if (w_match) r_cnt <= '0;
      else if (w_tick)  r_cnt <= r_cnt + 32'd1;
      if (w_wr_cmp)     r_cmp <= gptim_byte_merge(r_cmp, bus_wr_data, bus_we);
    end
  end

`ifdef GPTIM_PWM_EN
  logic [31:0] r_duty;
  logic        r_pwm;
  logic        w_wr_duty;

  assign w_wr_duty = w_wr & (w_word == GPTIM_DUTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (w_wr_duty) r_duty <= gptim_byte_merge(r_duty, bus_wr_data, bus_we);
      r_pwm <= r_conf.en & (r_cnt < r_duty);
    end
  end

  assign pwm_out   = r_pwm;
  assign w_duty_rd = r_duty;
`else
  assign pwm_out   = 1'b0;
  assign w_duty_rd = 32'd0;
`endif

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_word)
      GPTIM_CONF: w_rd_mux = r_conf;
      GPTIM_CNT:  w_rd_mux = r_cnt;
      GPTIM_CMP:  w_rd_mux = r_cmp;
      GPTIM_DUTY: w_rd_mux = w_duty_rd;
      default:    w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (w_rd) begin
      r_rd_data <= w_rd_mux;
    end
  end

  assign bus_rd_data = r_rd_data;
  assign irq         = r_conf.ie & r_conf.pend;

endmodule

// File: tb/tb_gptim.sv
// tb/tb_gptim.sv - self-checking bench for gptim: directed scenarios plus randomized traffic vs a reference model
module tb_gptim;

  logic        clk;
  logic        rst_n;
  logic        bus_en;
  logic [3:0]  bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        irq;
  logic        pwm_out;

  int n_checks = 0;
  int n_fail   = 0;

  gptim dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_en      (bus_en),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .irq         (irq),
    .pwm_out     (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: timer state as plain values; the prescaler is a countdown of
  // cycles remaining until the next tick.
  logic        m_en, m_os, m_ie, m_pend, m_pwm;
  logic [15:0] m_psc;
  logic [31:0] m_cnt, m_cmp, m_duty, m_rd;
  int          m_wait;

  function automatic logic [31:0] m_read(input logic [1:0] word);
    case (word)
      2'd0: return {m_psc, 12'd0, m_pend, m_ie, m_os, m_en};
      2'd1: return m_cnt;
      2'd2: return m_cmp;
`ifdef GPTIM_PWM_EN
      default: return m_duty;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_os = 0; m_ie = 0; m_pend = 0; m_pwm = 0;
    m_psc = 0; m_cnt = 0; m_cmp = 0; m_duty = 0; m_rd = 0; m_wait = 0;
  endtask

  task automatic m_step();
    logic        tick, match, restart;
    logic        n_en, n_os, n_ie, n_pend;
    logic [15:0] n_psc;
    logic [31:0] n_cnt, n_cmp, n_duty;
    n_en = m_en; n_os = m_os; n_ie = m_ie; n_pend = m_pend;
    n_psc = m_psc; n_cnt = m_cnt; n_cmp = m_cmp; n_duty = m_duty;
    tick  = m_en && (m_wait == 0);
    match = tick && (m_cnt == m_cmp);
    restart = tick || !m_en;
    if (match) begin
      n_cnt = 0; n_pend = 1;
      if (m_os) n_en = 0;
    end else if (tick) begin
      n_cnt = m_cnt + 1;
    end
`ifdef GPTIM_PWM_EN
    m_pwm = m_en && (m_cnt < m_duty);
`else
    m_pwm = 0;
`endif
    if (bus_en && bus_we == 4'd0) m_rd = m_read(bus_addr[3:2]);
    if (bus_en && bus_we != 4'd0) begin
      case (bus_addr[3:2])
        2'd0: begin
          if (bus_we[0]) begin
            n_en = bus_wr_data[0]; n_os = bus_wr_data[1]; n_ie = bus_wr_data[2];
            if (bus_wr_data[3] && !match) n_pend = 0;
          end
          if (bus_we[2]) n_psc[7:0]  = bus_wr_data[23:16];
          if (bus_we[3]) n_psc[15:8] = bus_wr_data[31:24];
          if (bus_we[2] || bus_we[3]) restart = 1;
        end
        2'd1: begin
          for (int b = 0; b < 4; b++) if (bus_we[b]) n_cnt[b*8 +: 8] = bus_wr_data[b*8 +: 8];
          restart = 1;
        end
        2'd2: for (int b = 0; b < 4; b++) if (bus_we[b]) n_cmp[b*8 +: 8] = bus_wr_data[b*8 +: 8];
        default: begin
`ifdef GPTIM_PWM_EN
          for (int b = 0; b < 4; b++) if (bus_we[b]) n_duty[b*8 +: 8] = bus_wr_data[b*8 +: 8];
`endif
        end
      endcase
    end
    m_wait = restart ? int'(n_psc) : m_wait - 1;
    m_en = n_en; m_os = n_os; m_ie = n_ie; m_pend = n_pend;
    m_psc = n_psc; m_cnt = n_cnt; m_cmp = n_cmp; m_duty = n_duty;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  task automatic cyc(input logic en, input logic [3:0] we, input logic [3:0] addr, input logic [31:0] wd);
    bus_en = en; bus_we = we; bus_addr = addr; bus_wr_data = wd;
    @(posedge clk);
    @(negedge clk);
    bus_en = 1'b0; bus_we = 4'd0;
    chk("irq", {31'd0, irq}, {31'd0, m_ie & m_pend});
    chk("pwm", {31'd0, pwm_out}, {31'd0, m_pwm});
    chk("rd_data", bus_rd_data, m_rd);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
    cyc(1'b1, 4'hF, addr, wd);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    cyc(1'b1, 4'h0, addr, 32'd0);
    data = bus_rd_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 4'h0, 32'd0);
  endtask

  task automatic wait_irq(input int max_cyc, output int lat);
    lat = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      idle(1);
      if (irq) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic stop_timer();
    wr(4'h0, 32'h8);
    wr(4'h4, 32'd0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_rd", bus_rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] rdata;
  int          lat;
  int          pwm_hi;
  int          op;

  initial begin
    rst_n = 1'b0; bus_en = 1'b0; bus_we = 4'd0; bus_addr = 4'd0; bus_wr_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_pwm", {31'd0, pwm_out}, 32'd0);
    chk("reset_rd", bus_rd_data, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(4'(a * 4), rdata);
      chk("reset_reg", rdata, 32'd0);
    end

    // 1: PSC=0, CMP=4 -> irq five cycles after enable; W1C clears it
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h5);
    wait_irq(20, lat);
    chk("t1_latency", lat, 32'd5);
    rd(4'h0, rdata);
    chk("t1_conf", rdata, 32'hD);
    cyc(1'b1, 4'h1, 4'h0, 32'hD);
    chk("t1_w1c", {31'd0, irq}, 32'd0);
    stop_timer();

    // 2: PSC=3, CMP=1 -> match on the second tick, eight cycles after enable
    wr(4'h8, 32'd1);
    wr(4'h0, 32'h0003_0005);
    wait_irq(20, lat);
    chk("t2_latency", lat, 32'd8);
    stop_timer();

    // 3: one-shot clears EN, counter parks at 0
    wr(4'h8, 32'd2);
    wr(4'h0, 32'h7);
    wait_irq(20, lat);
    chk("t3_latency", lat, 32'd3);
    rd(4'h0, rdata);
    chk("t3_conf", rdata, 32'hE);
    rd(4'h4, rdata);
    chk("t3_cnt", rdata, 32'd0);
    cyc(1'b1, 4'h1, 4'h0, 32'hE);
    idle(10);
    chk("t3_no_repend", {31'd0, irq}, 32'd0);
    rd(4'h4, rdata);
    chk("t3_cnt_hold", rdata, 32'd0);

    // 4: wrap from 2^32-1 gives no PEND, match later at 5
    stop_timer();
    wr(4'h8, 32'd5);
    wr(4'h4, 32'hFFFF_FFFF);
    wr(4'h0, 32'h5);
    wait_irq(20, lat);
    chk("t4_latency", lat, 32'd7);

    // 5: W1C coinciding with a match keeps PEND; byte write to CMP
    stop_timer();
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h5);
    wait_irq(20, lat);
    chk("t5_latency", lat, 32'd4);
    idle(3);
    cyc(1'b1, 4'h1, 4'h0, 32'hD);
    chk("t5_set_wins", {31'd0, irq}, 32'd1);
    cyc(1'b1, 4'h1, 4'h0, 32'hD);
    chk("t5_clear", {31'd0, irq}, 32'd0);
    stop_timer();
    wr(4'h8, 32'h1122_3344);
    cyc(1'b1, 4'b0001, 4'h8, 32'hAABB_CCDD);
    rd(4'h8, rdata);
    chk("t5_byte_we", rdata, 32'h1122_33DD);

    // 6: PWM duty
    stop_timer();
    wr(4'h8, 32'd9);
    wr(4'hC, 32'd3);
    wr(4'h0, 32'h1);
    idle(5);
    pwm_hi = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (pwm_out) pwm_hi++;
    end
    rd(4'hC, rdata);
`ifdef GPTIM_PWM_EN
    chk("t6_pwm_high", pwm_hi, 32'd6);
    chk("t6_duty", rdata, 32'd3);
`else
    chk("t6_pwm_high", pwm_hi, 32'd0);
    chk("t6_duty", rdata, 32'd0);
`endif

    // Randomized traffic against the model
    stop_timer();
    for (int it = 0; it < 800; it++) begin
      op = int'($urandom_range(0, 11));
      case (op)
        0, 1, 2, 3: idle(1);
        4: cyc(1'b1, 4'h0, 4'($urandom_range(0, 15)), 32'd0);
        5, 6: cyc(1'b1, 4'($urandom_range(0, 15)), 4'h0,
                  {14'd0, 2'($urandom_range(0, 3)), 12'd0, 4'($urandom_range(0, 15))});
        7: cyc(1'b1, 4'($urandom_range(1, 15)), 4'h8, 32'($urandom_range(0, 7)));
        8: cyc(1'b1, 4'hF, 4'h4, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 6)));
        9: cyc(1'b1, 4'hF, 4'hC, 32'($urandom_range(0, 9)));
        10: cyc(1'b1, 4'h1, 4'h0, 32'h0000_000D);
        default: if ($urandom_range(0, 19) == 0) mid_reset(); else idle(1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
